// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MAU_ADDR_W = 32;

    typedef enum logic [1:0] {
        MS_BYTE = 2'b00,
        MS_HALF = 2'b01,
        MS_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mau_state_t;

    // Size code 2'b11 falls into the word case.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            MS_BYTE: r = 1'b0;
            MS_HALF: r = addr_lo[0];
            default: r = |addr_lo;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Byte-lane steering for stores and lane extraction for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        misaligned = is_misaligned(st_size, st_addr_lo);
        st_be      = 4'b1111;
        st_lanes   = st_wdata;
        case (st_size)
            MS_BYTE: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_lanes = {4{st_wdata[7:0]}};
            end
            MS_HALF: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = st_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte   = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        w_half   = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_value = ld_rdata;
        case (ld_size)
            MS_BYTE: ld_value = ld_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            MS_HALF: ld_value = ld_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: ld_value = ld_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MIPS MEM stage; req/ack data-memory access with stall control.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = MAU_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [1:0]        MemSize_in,
    input  logic              MemSigned_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [4:0]        WriteReg_in,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] ALUResult_out,
    output logic [4:0]        WriteReg_out,
    output logic              stall,
    output logic              addr_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    mau_state_t        r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_is_load;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [4:0]        r_writereg;
    logic [DATA_W-1:0] r_alu;

    logic              w_mem_op;
    logic              w_misaligned;
    logic              w_accept;
    logic [3:0]        w_st_be;
    logic [DATA_W-1:0] w_st_lanes;
    logic [DATA_W-1:0] w_ld_value;

    assign w_mem_op = ex_valid & (MemRead_in | MemWrite_in);
    assign w_accept = (r_state == IDLE) & w_mem_op & ~w_misaligned;

    load_store_align u_align (
        .st_size    (MemSize_in),
        .st_addr_lo (ALUResult_in[1:0]),
        .st_wdata   (WriteData_in),
        .st_be      (w_st_be),
        .st_lanes   (w_st_lanes),
        .misaligned (w_misaligned),
        .ld_size    (r_size),
        .ld_addr_lo (r_alu[1:0]),
        .ld_signed  (r_signed),
        .ld_rdata   (dmem_rdata),
        .ld_value   (w_ld_value)
    );

    always_comb begin
        RegWrite_out  = 1'b0;
        MemtoReg_out  = 1'b0;
        ReadData_out  = '0;
        ALUResult_out = '0;
        WriteReg_out  = '0;
        stall         = 1'b0;
        addr_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && w_misaligned) begin
                    // Faulting access is dropped: no write-back, no bus cycle.
                    addr_err      = 1'b1;
                    ALUResult_out = ALUResult_in;
                    WriteReg_out  = WriteReg_in;
                end else if (w_mem_op) begin
                    stall = 1'b1;
                end else if (ex_valid) begin
                    RegWrite_out  = RegWrite_in;
                    MemtoReg_out  = MemtoReg_in;
                    ALUResult_out = ALUResult_in;
                    WriteReg_out  = WriteReg_in;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    RegWrite_out  = r_regwrite;
                    MemtoReg_out  = r_memtoreg;
                    ALUResult_out = r_alu;
                    WriteReg_out  = r_writereg;
                    ReadData_out  = r_is_load ? w_ld_value : '0;
                end else begin
                    stall = 1'b1;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_is_load  <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_writereg <= '0;
            r_alu      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= BUSY;
                        r_req      <= 1'b1;
                        r_we       <= MemWrite_in & ~MemRead_in;
                        r_addr     <= {ALUResult_in[ADDR_W-1:2], 2'b00};
                        r_be       <= w_st_be;
                        r_wdata    <= MemRead_in ? '0 : w_st_lanes;
                        r_size     <= MemSize_in;
                        r_signed   <= MemSigned_in;
                        r_is_load  <= MemRead_in;
                        r_regwrite <= RegWrite_in;
                        r_memtoreg <= MemtoReg_in;
                        r_writereg <= WriteReg_in;
                        r_alu      <= ALUResult_in;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_be    <= '0;
                        r_wdata <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire
